// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
// Arbiter state encodings and default data-path widths.
package data_mem_arbiter_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BURST   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used for the p1 wait counter and the burst length counter.
module arb_sat_counter #(
   parameter int W     = 4,
   parameter int LIMIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   // Clear wins over increment; counting stops at LIMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != LIM)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory.
// p0 has priority; p1 has anti-starvation and burst lock.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic              p1_lock,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam logic [3:0] WAIT_LIM   = 4'(MAX_WAIT);
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   arb_state_e state, state_nxt;
   logic [3:0] wait_cnt;
   logic [7:0] burst_cnt;
   logic       g0, g1;
   logic       b_inc, b_clr;
   logic       w_inc, w_clr;
   logic       rv0_q, rv1_q;

   arb_sat_counter #(.W(4), .LIMIT(MAX_WAIT)) u_wait (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .inc   (w_inc),
      .count (wait_cnt)
   );

   arb_sat_counter #(.W(8), .LIMIT(MAX_BURST)) u_burst (
      .clk   (clk),
      .reset (reset),
      .clr   (b_clr),
      .inc   (b_inc),
      .count (burst_cnt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ARB_IDLE;
      else       state <= state_nxt;
   end

   // Grant selection and next-state decode.
   always_comb begin
      state_nxt = state;
      g0        = 1'b0;
      g1        = 1'b0;
      b_inc     = 1'b0;
      b_clr     = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (p1_req && (!p0_req || wait_cnt == WAIT_LIM)) g1 = 1'b1;
            else if (p0_req)                                 g0 = 1'b1;
            if (g1 && p1_lock) begin
               state_nxt = ARB_BURST;
               b_inc     = 1'b1;
            end
         end
         ARB_BURST: begin
            g1 = p1_req;
            if (!p1_lock) begin
               state_nxt = ARB_IDLE;
               b_clr     = 1'b1;
            end else begin
               b_inc = 1'b1;
               if (burst_cnt == BURST_LAST) state_nxt = ARB_RELEASE;
            end
         end
         ARB_RELEASE: begin
            g0        = p0_req;
            g1        = p1_req && !p0_req;
            b_clr     = 1'b1;
            state_nxt = ARB_IDLE;
         end
         default: begin
            state_nxt = ARB_IDLE;
            b_clr     = 1'b1;
         end
      endcase
   end

   // Grants are suppressed during reset so nothing commits.
   always_comb begin
      p0_gnt = g0 && !reset;
      p1_gnt = g1 && !reset;
      w_clr  = p1_gnt || !p1_req;
      w_inc  = (state == ARB_IDLE) && p1_req && !p1_gnt;
   end

   // Memory mux: the winner drives the memory, idle drives zero.
   always_comb begin
      mem_address    = '0;
      mem_write_data = '0;
      mem_write      = 1'b0;
      mem_read       = 1'b0;
      if (p0_gnt) begin
         mem_address    = p0_addr;
         mem_write_data = p0_wdata;
         mem_write      = p0_we;
         mem_read       = !p0_we;
      end else if (p1_gnt) begin
         mem_address    = p1_addr;
         mem_write_data = p1_wdata;
         mem_write      = p1_we;
         mem_read       = !p1_we;
      end
   end

   // Read return: capture data at the grant edge, pulse rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else begin
         rv0_q <= p0_gnt && !p0_we;
         rv1_q <= p1_gnt && !p1_we;
         if (p0_gnt && !p0_we) p0_rdata <= mem_read_data;
         if (p1_gnt && !p1_we) p1_rdata <= mem_read_data;
      end
   end

   // A pending rvalid is dropped as soon as reset is seen.
   always_comb begin
      p0_rvalid = rv0_q && !reset;
      p1_rvalid = rv1_q && !reset;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter.
// Includes a behavioural 256x16 data memory.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [15:0] p0_rdata, p1_rdata;
   logic [15:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write, mem_read;
   logic [15:0] mem [256];

   int checks = 0;
   int errors = 0;
   int n;
   logic exp1;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_write) mem[mem_address[8:1]] <= mem_write_data;

   assign mem_read_data = mem[mem_address[8:1]];

   data_mem_arbiter #(
      .DATA_W(16), .ADDR_W(16), .MAX_WAIT(4), .MAX_BURST(8)
   ) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
      .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt),
      .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_read_data(mem_read_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
      p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic l,
                       input logic [15:0] a, input logic [15:0] d);
      p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_wdata = d;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      set0(0, 0, 16'h0, 16'h0);
      set1(0, 0, 0, 16'h0, 16'h0);
      cyc(); cyc();
      #1;
      chk("rst_gnt", 64'({p0_gnt, p1_gnt}), 64'(0));
      chk("rst_mem", 64'({mem_write, mem_read}), 64'(0));
      chk("rst_rv", 64'({p0_rvalid, p1_rvalid}), 64'(0));
      chk("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));

      // p0 write then read back
      cyc(); reset = 1'b0;
      set0(1, 1, 16'h0004, 16'h1234);
      #1;
      chk("wr_gnt", 64'({p0_gnt, p1_gnt}), 64'(2'b10));
      chk("wr_bus", 64'({mem_write, mem_read, mem_address, mem_write_data}),
          64'({2'b10, 16'h0004, 16'h1234}));
      cyc();
      set0(1, 0, 16'h0004, 16'h0);
      #1;
      chk("rd_gnt", 64'({p0_gnt, mem_read, mem_write, p0_rvalid}),
          64'(4'b1100));
      cyc();
      set0(0, 0, 16'h0, 16'h0);
      #1;
      chk("rd_data", 64'({p0_rvalid, p0_rdata}), 64'({1'b1, 16'h1234}));
      cyc(); #1;
      chk("rd_pulse", 64'(p0_rvalid), 64'(0));

      // anti-starvation: p1 wins every 5th cycle
      cyc();
      set0(1, 0, 16'h0006, 16'h0);
      set1(1, 0, 0, 16'h0008, 16'h0);
      for (int k = 0; k < 10; k++) begin
         #1;
         exp1 = (k % 5 == 4);
         chk($sformatf("wait_k%0d", k), 64'({p0_gnt, p1_gnt}),
             64'({!exp1, exp1}));
         cyc();
      end
      set0(0, 0, 16'h0, 16'h0);
      set1(0, 0, 0, 16'h0, 16'h0);
      cyc();

      // locked burst of 12 p1 writes with p0 always requesting
      n = 0;
      set0(1, 0, 16'h0006, 16'h0);
      set1(1, 1, 1, 16'h0010, 16'hA000);
      for (int k = 0; k < 23; k++) begin
         #1;
         exp1 = (k >= 4 && k <= 11) || (k >= 17 && k <= 20);
         chk($sformatf("burst_k%0d", k), 64'({p0_gnt, p1_gnt}),
             64'({!exp1 && k != 21, exp1}));
         if (p1_gnt) chk("burst_we", 64'(mem_write), 64'(1));
         cyc();
         if (exp1) n++;
         if (n == 12) set1(0, 0, 0, 16'h0, 16'h0);
         else         p1_wdata = 16'hA000 + 16'(n);
      end
      chk("burst_mem", 64'(mem[8'h08]), 64'(16'hA00B));
      set0(0, 0, 16'h0, 16'h0);
      cyc();

      // reset in the cycle a p1 write would be granted
      set0(1, 1, 16'h0020, 16'h5555);
      cyc();
      set0(0, 0, 16'h0, 16'h0);
      set1(1, 1, 0, 16'h0020, 16'hBEEF);
      reset = 1'b1;
      #1;
      chk("rstw_gnt", 64'({p1_gnt, mem_write}), 64'(0));
      cyc();
      reset = 1'b0;
      set1(0, 0, 0, 16'h0, 16'h0);
      set0(1, 0, 16'h0020, 16'h0);
      cyc();
      set0(0, 0, 16'h0, 16'h0);
      #1;
      chk("rstw_mem", 64'({p0_rvalid, p0_rdata}), 64'({1'b1, 16'h5555}));

      // reset mid-burst returns to IDLE
      cyc();
      set1(1, 1, 1, 16'h0030, 16'h1111);
      cyc(); cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      set0(1, 0, 16'h0006, 16'h0);
      set1(1, 1, 0, 16'h0030, 16'h2222);
      #1;
      chk("rstb_idle", 64'({p0_gnt, p1_gnt}), 64'(2'b10));
      cyc();
      set0(0, 0, 16'h0, 16'h0);
      set1(0, 0, 0, 16'h0, 16'h0);
      cyc();

      // p1 read granted, reset next cycle drops rvalid
      set1(1, 0, 0, 16'h0002, 16'h0);
      #1;
      chk("rdrst_gnt", 64'({p1_gnt, mem_read}), 64'(2'b11));
      cyc();
      set1(0, 0, 0, 16'h0, 16'h0);
      reset = 1'b1;
      #1;
      chk("rdrst_rv0", 64'(p1_rvalid), 64'(0));
      cyc();
      reset = 1'b0;
      #1;
      chk("rdrst_rv1", 64'({p1_rvalid, p1_rdata}), 64'(0));

      // idle: no requests for 10 cycles
      for (int k = 0; k < 10; k++) begin
         cyc(); #1;
         chk($sformatf("idle_k%0d", k),
             64'({mem_address, mem_write_data, mem_write, mem_read,
                  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}), 64'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
